multicycle_ctrl_fsm: RTL and testbench

- Main control state machine for the multicycle RV32I core. It sits directly upstream of the ALU decoder and drives its `ALUOp` input.
- Sequences every instruction through fetch, decode, execute, memory and writeback, and generates all datapath enables and mux selects.
- Stalls on a simple memory request/ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_ctrl_fsm.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable, mux select and the ALU decoder op.
module multicycle_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state, state_nxt;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; the async reset drops to FETCH without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= state_t'(RESET_STATE);
    else        state <= state_nxt;
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_LOAD, OP_ITYPE: imm_src = 3'b000;
      OP_STORE:          imm_src = 3'b001;
      OP_BRANCH:         imm_src = 3'b010;
      OP_JAL:            imm_src = 3'b011;
      OP_LUI:            imm_src = 3'b100;
      default:           imm_src = 3'b000;
    endcase
  end

  // NOTE: every output and the next state get a default before the case so no
  // path through this block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt     = FETCH;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_instr = 1'b0;

    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        result_src = 2'b10;
        alu_src_b  = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_nxt  = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXEC_R;
          OP_ITYPE:          state_nxt = EXEC_I;
          OP_BRANCH:         state_nxt = (funct3[2:1] == 2'b00) ? BRANCH : ILLEGAL;
          OP_JAL:            state_nxt = JAL;
          OP_LUI:            state_nxt = LUI;
          default:           state_nxt = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_nxt = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        state_nxt = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_nxt  = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        state_nxt = mem_ready ? FETCH : MEMWRITE;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_nxt = ALUWB;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        // funct3[0] inverts the sense of zero: beq takes on equal, bne on unequal.
        pc_write  = zero ^ funct3[0];
        state_nxt = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_nxt = ALUWB;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_nxt = ALUWB;
      end
      ILLEGAL: begin
        illegal_instr = 1'b1;
        state_nxt     = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Table-driven bench for multicycle_ctrl_fsm: per-cycle input/expected-output records
// plus hand-written reset and asynchronous reset-during-store sequences.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic       illegal_instr;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //  result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr}
  logic [17:0] act;
  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr};

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        zero;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [6:0] LW  = 7'b0000011, SW  = 7'b0100011, RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011, BR  = 7'b1100011, JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111, BAD = 7'b1111111;

  function automatic logic [17:0] pk(input logic mreq, mwr, adr, irw, pcw, rgw,
                                     input logic [1:0] rs, a, b, aop);
    return {mreq, mwr, adr, irw, pcw, rgw, rs, a, b, aop, 3'b000, 1'b0};
  endfunction

  function automatic logic [17:0] im(input logic [2:0] x);
    return {14'b0, x, 1'b0};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic add(input string nm, input logic [6:0] o, input logic [2:0] f,
                     input logic z, input logic r, input logic [17:0] e);
    vec_t v;
    v.name = nm; v.op = o; v.f3 = f; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  logic [17:0] s_f0, s_f1, s_dec, s_madr, s_mrd, s_mwb, s_mwr, s_exr, s_exi;
  logic [17:0] s_awb, s_br0, s_br1, s_jal, s_lui, s_ill;

  initial begin
    s_f0   = pk(1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00);
    s_f1   = pk(1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 2'b00);
    s_dec  = pk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00);
    s_madr = pk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00);
    s_mrd  = pk(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00);
    s_mwb  = pk(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00);
    s_mwr  = pk(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00);
    s_exr  = pk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10);
    s_exi  = pk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10);
    s_awb  = pk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00);
    s_br0  = pk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01);
    s_br1  = pk(0,0,0,0,1,0, 2'b00, 2'b10, 2'b00, 2'b01);
    s_jal  = pk(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 2'b00);
    s_lui  = pk(0,0,0,0,0,0, 2'b00, 2'b11, 2'b01, 2'b00);
    s_ill  = 18'h00001;

    // lw, no stalls: 5 cycles
    add("lw fetch",  LW, 3'b010, 0, 1, s_f1);
    add("lw decode", LW, 3'b010, 0, 1, s_dec);
    add("lw memadr", LW, 3'b010, 0, 1, s_madr);
    add("lw memrd",  LW, 3'b010, 0, 1, s_mrd);
    add("lw memwb",  LW, 3'b010, 0, 1, s_mwb);
    // lw with two read-stall cycles
    add("lws fetch",  LW, 3'b010, 0, 1, s_f1);
    add("lws decode", LW, 3'b010, 0, 1, s_dec);
    add("lws memadr", LW, 3'b010, 0, 1, s_madr);
    add("lws stall1", LW, 3'b010, 0, 0, s_mrd);
    add("lws stall2", LW, 3'b010, 0, 0, s_mrd);
    add("lws memrd",  LW, 3'b010, 0, 1, s_mrd);
    add("lws memwb",  LW, 3'b010, 0, 1, s_mwb);
    // sw, no stalls: 4 cycles
    add("sw fetch",  SW, 3'b010, 0, 1, s_f1  | im(3'b001));
    add("sw decode", SW, 3'b010, 0, 1, s_dec | im(3'b001));
    add("sw memadr", SW, 3'b010, 0, 1, s_madr| im(3'b001));
    add("sw memwr",  SW, 3'b010, 0, 1, s_mwr | im(3'b001));
    // R-type after three fetch-stall cycles
    add("r stall1", RT, 3'b000, 0, 0, s_f0);
    add("r stall2", RT, 3'b000, 0, 0, s_f0);
    add("r stall3", RT, 3'b000, 0, 0, s_f0);
    add("r fetch",  RT, 3'b000, 0, 1, s_f1);
    add("r decode", RT, 3'b000, 0, 1, s_dec);
    add("r exec",   RT, 3'b000, 0, 1, s_exr);
    add("r aluwb",  RT, 3'b000, 0, 1, s_awb);
    // I-ALU
    add("i fetch",  IT, 3'b000, 0, 1, s_f1);
    add("i decode", IT, 3'b000, 0, 1, s_dec);
    add("i exec",   IT, 3'b000, 0, 1, s_exi);
    add("i aluwb",  IT, 3'b000, 0, 1, s_awb);
    // branches: taken iff zero XOR funct3[0]
    add("beq z1 fetch",  BR, 3'b000, 1, 1, s_f1  | im(3'b010));
    add("beq z1 decode", BR, 3'b000, 1, 1, s_dec | im(3'b010));
    add("beq z1 branch", BR, 3'b000, 1, 1, s_br1 | im(3'b010));
    add("bne z1 fetch",  BR, 3'b001, 1, 1, s_f1  | im(3'b010));
    add("bne z1 decode", BR, 3'b001, 1, 1, s_dec | im(3'b010));
    add("bne z1 branch", BR, 3'b001, 1, 1, s_br0 | im(3'b010));
    add("beq z0 fetch",  BR, 3'b000, 0, 1, s_f1  | im(3'b010));
    add("beq z0 decode", BR, 3'b000, 0, 1, s_dec | im(3'b010));
    add("beq z0 branch", BR, 3'b000, 0, 1, s_br0 | im(3'b010));
    add("bne z0 fetch",  BR, 3'b001, 0, 1, s_f1  | im(3'b010));
    add("bne z0 decode", BR, 3'b001, 0, 1, s_dec | im(3'b010));
    add("bne z0 branch", BR, 3'b001, 0, 1, s_br1 | im(3'b010));
    // jal and lui
    add("jal fetch",  JL, 3'b000, 0, 1, s_f1  | im(3'b011));
    add("jal decode", JL, 3'b000, 0, 1, s_dec | im(3'b011));
    add("jal jal",    JL, 3'b000, 0, 1, s_jal | im(3'b011));
    add("jal aluwb",  JL, 3'b000, 0, 1, s_awb | im(3'b011));
    add("lui fetch",  LU, 3'b000, 0, 1, s_f1  | im(3'b100));
    add("lui decode", LU, 3'b000, 0, 1, s_dec | im(3'b100));
    add("lui lui",    LU, 3'b000, 0, 1, s_lui | im(3'b100));
    add("lui aluwb",  LU, 3'b000, 0, 1, s_awb | im(3'b100));
    // illegal opcodes: one-cycle pulse then FETCH
    add("ill fetch",  BAD, 3'b000, 0, 1, s_f1);
    add("ill decode", BAD, 3'b000, 0, 1, s_dec);
    add("ill pulse",  BAD, 3'b000, 0, 1, s_ill);
    add("illb fetch", BR,  3'b100, 0, 1, s_f1  | im(3'b010));
    add("illb decode",BR,  3'b100, 0, 1, s_dec | im(3'b010));
    add("illb pulse", BR,  3'b100, 0, 1, s_ill | im(3'b010));
    // sw stalled in MEMWRITE; reset arrives afterwards
    add("sws fetch",  SW, 3'b010, 0, 1, s_f1  | im(3'b001));
    add("sws decode", SW, 3'b010, 0, 1, s_dec | im(3'b001));
    add("sws memadr", SW, 3'b010, 0, 1, s_madr| im(3'b001));
    add("sws stall1", SW, 3'b010, 0, 0, s_mwr | im(3'b001));
    add("sws stall2", SW, 3'b010, 0, 0, s_mwr | im(3'b001));

    // reset held for two cycles; outputs must show the FETCH decode
    rst_n = 1'b0; op = LW; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    #1 check("reset rdy0", act, s_f0);
    mem_ready = 1'b1;
    #1 check("reset rdy1", act, s_f1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      op = vecs[i].op; funct3 = vecs[i].f3; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      #1 check(vecs[i].name, act, vecs[i].exp);
      check({vecs[i].name, " inv"}, {16'b0, mem_write & ~mem_req, reg_write & mem_write}, 18'b0);
      @(negedge clk);
    end

    // still stalled in MEMWRITE; drop rst_n between edges
    #1 check("pre-reset mem_write", {17'b0, mem_write}, 18'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async reset decode", act, s_f0 | im(3'b001));
    check("async reset mem_write", {17'b0, mem_write}, 18'b0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    #1 check("post-reset fetch", act, s_f1 | im(3'b001));
    @(negedge clk);
    #1 check("post-reset decode", act, s_dec | im(3'b001));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
